// File: rtl/full_adder_bist_checker.sv
// -----------------------------------------------------------------------------
// full_adder_bist_checker
//
// Built-in self-test engine for a 1-bit combinational full adder. A run walks
// all eight input vectors {a,b,c} = 000..111 in ascending order. Each vector is
// held for SETTLE_CYCLES cycles and then the adder's {carry,sum} response is
// compared with the arithmetic result a+b+c during a one-cycle CHECK slot.
// At the end of the run it reports pass/fail, a saturating mismatch count and
// the first vector that mismatched.
//
// Parameters
//   SETTLE_CYCLES  cycles each vector is held before sampling (>= 1)
//   ERR_W          width of the saturating mismatch counter
//
// Ports
//   clk             in   single clock, rising edge
//   rst_n           in   asynchronous active-low reset
//   start           in   begin a run; only honoured in IDLE
//   a_o, b_o, c_o   out  registered stimulus to the adder under test
//   sum_i, carry_i  in   adder response; only looked at during CHECK
//   busy            out  high from the cycle after an accepted start until
//                        the DONE cycle has completed
//   done            out  one-cycle pulse in the DONE state
//   pass            out  last run had zero mismatches; held until next start
//   err_count       out  mismatches in the current/last run, saturating
//   fail_valid      out  at least one mismatch in the current/last run
//   first_fail_vec  out  {a,b,c} of the first mismatch; valid with fail_valid
// -----------------------------------------------------------------------------
module full_adder_bist_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a_o,
  output logic             b_o,
  output logic             c_o,
  input  logic             sum_i,
  input  logic             carry_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [2:0]       first_fail_vec
);

  // The settle counter counts down from SETTLE_CYCLES-1 to 0, so it needs to
  // hold SETTLE_CYCLES-1; keep at least one bit for the SETTLE_CYCLES == 1 case.
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_CHECK  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       vec_q, vec_d;
  logic [2:0]       stim_q, stim_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             fail_valid_q, fail_valid_d;
  logic [2:0]       first_fail_q, first_fail_d;
  logic             mismatch;

  // Arithmetic reference: the 2-bit sum of three 1-bit operands, {carry,sum}.
  function automatic logic [1:0] expected_resp(input logic [2:0] v);
    return {1'b0, v[2]} + {1'b0, v[1]} + {1'b0, v[0]};
  endfunction

  // Saturating increment: once all ones the counter sticks there.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] x);
    return (&x) ? x : x + ERR_W'(1);
  endfunction

  // Compared against the vector actually being driven. The result is only
  // consumed in CHECK, so an undefined response in other states never reaches
  // any register.
  assign mismatch = ({carry_i, sum_i} != expected_resp(stim_q));

  // ---------------------------------------------------------------------------
  // Next-state and result update
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    stim_d       = stim_q;
    cnt_d        = cnt_q;
    busy_d       = busy_q;
    pass_d       = pass_q;
    err_d        = err_q;
    fail_valid_d = fail_valid_q;
    first_fail_d = first_fail_q;

    case (state_q)
      S_IDLE: begin
        stim_d = 3'b000;
        if (start) begin
          vec_d        = 3'd0;
          stim_d       = 3'b000;
          err_d        = '0;
          fail_valid_d = 1'b0;
          first_fail_d = 3'b000;
          pass_d       = 1'b0;
          cnt_d        = SETTLE_LOAD;
          busy_d       = 1'b1;
          state_d      = S_SETTLE;
        end
      end

      S_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_CHECK: begin
        if (mismatch) begin
          err_d = sat_inc(err_q);
          // Only the first failure of a run is latched.
          if (!fail_valid_q) begin
            fail_valid_d = 1'b1;
            first_fail_d = vec_q;
          end
        end
        if (vec_q == 3'd7) begin
          state_d = S_DONE;
        end else begin
          vec_d   = vec_q + 3'd1;
          stim_d  = vec_q + 3'd1;
          cnt_d   = SETTLE_LOAD;
          state_d = S_SETTLE;
        end
      end

      S_DONE: begin
        // err_q already includes the final CHECK of this run.
        busy_d  = 1'b0;
        pass_d  = (err_q == '0);
        stim_d  = 3'b000;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      vec_q        <= 3'd0;
      stim_q       <= 3'b000;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      first_fail_q <= 3'b000;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      stim_q       <= stim_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      pass_q       <= pass_d;
      err_q        <= err_d;
      fail_valid_q <= fail_valid_d;
      first_fail_q <= first_fail_d;
    end
  end

  assign a_o            = stim_q[2];
  assign b_o            = stim_q[1];
  assign c_o            = stim_q[0];
  assign busy           = busy_q;
  assign done           = (state_q == S_DONE);
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign fail_valid     = fail_valid_q;
  assign first_fail_vec = first_fail_q;

endmodule

// File: tb/tb_full_adder_bist_checker.sv
// -----------------------------------------------------------------------------
// Bench for full_adder_bist_checker. Three instances are used:
//   0: default parameters, 1: ERR_W = 2, 2: SETTLE_CYCLES = 1.
// Each instance faces a behavioural adder whose behaviour is selected per
// scenario (golden, carry stuck-at-0, sum inverted, or a random response table).
// -----------------------------------------------------------------------------
module tb_full_adder_bist_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start  [3];
  logic       a_w    [3];
  logic       b_w    [3];
  logic       c_w    [3];
  logic [2:0] stim   [3];
  logic [1:0] resp   [3];
  logic       busy   [3];
  logic       done   [3];
  logic       pass   [3];
  logic       fvalid [3];
  logic [2:0] ffv    [3];
  logic [3:0] errc   [3];
  logic [3:0] err0, err2;
  logic [1:0] err1;

  int         fmode  [3];
  logic [1:0] ftab   [3][8];

  int n_vec  = 0;
  int n_miss = 0;

  // Adder under test. mode 0 golden, 1 carry stuck at 0, 2 sum inverted,
  // 3 arbitrary response table.
  function automatic logic [1:0] adut_resp(input int mode, input logic [1:0] tab,
                                           input logic [2:0] v);
    int   s;
    logic sb, cb;
    s  = int'(v[2]) + int'(v[1]) + int'(v[0]);
    sb = (s % 2) == 1;
    cb = s >= 2;
    case (mode)
      1:       return {1'b0, sb};
      2:       return {cb, ~sb};
      3:       return tab;
      default: return {cb, sb};
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_adut
    assign stim[g] = {a_w[g], b_w[g], c_w[g]};
    assign resp[g] = adut_resp(fmode[g], ftab[g][stim[g]], stim[g]);
  end
  assign errc[0] = err0;
  assign errc[1] = {2'b00, err1};
  assign errc[2] = err2;

  full_adder_bist_checker u0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]),
    .a_o(a_w[0]), .b_o(b_w[0]), .c_o(c_w[0]),
    .sum_i(resp[0][0]), .carry_i(resp[0][1]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(err0),
    .fail_valid(fvalid[0]), .first_fail_vec(ffv[0])
  );

  full_adder_bist_checker #(.ERR_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]),
    .a_o(a_w[1]), .b_o(b_w[1]), .c_o(c_w[1]),
    .sum_i(resp[1][0]), .carry_i(resp[1][1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(err1),
    .fail_valid(fvalid[1]), .first_fail_vec(ffv[1])
  );

  full_adder_bist_checker #(.SETTLE_CYCLES(1)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]),
    .a_o(a_w[2]), .b_o(b_w[2]), .c_o(c_w[2]),
    .sum_i(resp[2][0]), .carry_i(resp[2][1]),
    .busy(busy[2]), .done(done[2]), .pass(pass[2]), .err_count(err2),
    .fail_valid(fvalid[2]), .first_fail_vec(ffv[2])
  );

  // Reference model: count vectors whose response differs from a+b+c.
  task automatic model(input int i, output int nmis, output logic [3:0] exp_err,
                       output logic [2:0] exp_first);
    int w, cap, e;
    logic [1:0] got;
    w = (i == 1) ? 2 : 4;
    cap = (1 << w) - 1;
    nmis = 0;
    exp_first = 3'b000;
    for (int v = 0; v < 8; v++) begin
      got = adut_resp(fmode[i], ftab[i][v], 3'(v));
      e = (v & 1) + ((v >> 1) & 1) + ((v >> 2) & 1);
      if (int'(got) != e) begin
        if (nmis == 0) exp_first = 3'(v);
        nmis++;
      end
    end
    exp_err = 4'((nmis > cap) ? cap : nmis);
  endtask

  // Launch a run on instance i and observe it cycle by cycle; t counts the
  // cycles after the edge that accepted start. Stimulus and busy are expected
  // to follow the vector schedule: vector t/P for t < 8P, 111 during DONE,
  // then 000.
  task automatic run_obs(input int i, input bit inj, input bit hold,
                         output int first_done, output int last_done, output int ndone,
                         output int seq_bad, output int busy_bad, output logic pass0);
    int p, l, tmax;
    logic [2:0] ev;
    p = (i == 2) ? 2 : 3;
    l = 8 * p;
    tmax = hold ? 2 * l + 4 : l + 4;
    first_done = -1; last_done = -1; ndone = 0; seq_bad = 0; busy_bad = 0; pass0 = 1'b0;
    @(negedge clk);
    start[i] = 1'b1;
    @(posedge clk);
    #1;
    for (int t = 0; t <= tmax; t++) begin
      if (t > 0) begin
        @(posedge clk);
        #1;
      end
      start[i] = hold ? (t < 2 * l + 2) : (inj && (t == 5 || t == 13 || t == l - 1 || t == l));
      if (t == 0) pass0 = pass[i];
      if (done[i] === 1'b1) begin
        ndone++;
        if (first_done < 0) first_done = t;
        last_done = t;
      end
      if (t <= l + 1) begin
        ev = (t < l) ? 3'(t / p) : ((t == l) ? 3'd7 : 3'd0);
        if (stim[i] !== ev) seq_bad++;
        if (busy[i] !== 1'(t <= l)) busy_bad++;
      end
    end
    start[i] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0;
      fmode[i] = 0;
      for (int v = 0; v < 8; v++) ftab[i][v] = 2'b00;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if ({stim[i], busy[i], done[i], pass[i], fvalid[i], ffv[i], errc[i]} !== 14'd0) begin
        n_miss++;
        $display("FAIL reset_outputs inst%0d: got stim=%b busy=%b done=%b pass=%b fv=%b ffv=%b err=%0d want all 0",
                 i, stim[i], busy[i], done[i], pass[i], fvalid[i], ffv[i], errc[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_golden();
    int fd, ld, nd, sb, bb; logic p0;
    fmode[0] = 0;
    run_obs(0, 1'b0, 1'b0, fd, ld, nd, sb, bb, p0);
    n_vec++; if (fd !== 24) begin n_miss++; $display("FAIL golden_done_cycle: got %0d want 24", fd); end
    n_vec++; if (nd !== 1) begin n_miss++; $display("FAIL golden_done_count: got %0d want 1", nd); end
    n_vec++; if (sb !== 0) begin n_miss++; $display("FAIL golden_stim_seq: got %0d bad cycles want 0", sb); end
    n_vec++; if (bb !== 0) begin n_miss++; $display("FAIL golden_busy: got %0d bad cycles want 0", bb); end
    n_vec++; if ({pass[0], fvalid[0], errc[0]} !== 6'b10_0000) begin
      n_miss++; $display("FAIL golden_result: got pass=%b fv=%b err=%0d want pass=1 fv=0 err=0",
                          pass[0], fvalid[0], errc[0]);
    end
  endtask

  task automatic test_carry_stuck();
    int fd, ld, nd, sb, bb, nm; logic p0; logic [3:0] ee; logic [2:0] ef;
    fmode[0] = 1;
    model(0, nm, ee, ef);
    run_obs(0, 1'b0, 1'b0, fd, ld, nd, sb, bb, p0);
    n_vec++; if (errc[0] !== 4'd4 || errc[0] !== ee) begin
      n_miss++; $display("FAIL carry_err_count: got %0d want 4 (model %0d)", errc[0], ee);
    end
    n_vec++; if (ffv[0] !== 3'b011 || ffv[0] !== ef) begin
      n_miss++; $display("FAIL carry_first_vec: got %b want 011", ffv[0]);
    end
    n_vec++; if ({fvalid[0], pass[0]} !== 2'b10) begin
      n_miss++; $display("FAIL carry_flags: got fv=%b pass=%b want fv=1 pass=0", fvalid[0], pass[0]);
    end
    n_vec++; if (fd !== 24) begin n_miss++; $display("FAIL carry_done_cycle: got %0d want 24", fd); end
  endtask

  task automatic test_sum_inverted_sat();
    int fd, ld, nd, sb, bb, nm; logic p0; logic [3:0] ee; logic [2:0] ef;
    fmode[1] = 2;
    model(1, nm, ee, ef);
    run_obs(1, 1'b0, 1'b0, fd, ld, nd, sb, bb, p0);
    n_vec++; if (err1 !== 2'b11 || errc[1] !== ee) begin
      n_miss++; $display("FAIL suminv_err_sat: got %b want 11 (model %0d, %0d mismatches)", err1, ee, nm);
    end
    n_vec++; if (ffv[1] !== 3'b000 || fvalid[1] !== 1'b1) begin
      n_miss++; $display("FAIL suminv_first_vec: got ffv=%b fv=%b want ffv=000 fv=1", ffv[1], fvalid[1]);
    end
    n_vec++; if (pass[1] !== 1'b0) begin n_miss++; $display("FAIL suminv_pass: got %b want 0", pass[1]); end
  endtask

  task automatic test_extra_start();
    int fd, ld, nd, sb, bb; logic p0; int held_bad;
    fmode[0] = 1;
    run_obs(0, 1'b1, 1'b0, fd, ld, nd, sb, bb, p0);
    n_vec++; if (nd !== 1 || fd !== 24) begin
      n_miss++; $display("FAIL extra_start_done: got %0d pulses first at %0d want 1 at 24", nd, fd);
    end
    n_vec++; if (sb !== 0 || bb !== 0) begin
      n_miss++; $display("FAIL extra_start_seq: got %0d stim / %0d busy bad cycles want 0", sb, bb);
    end
    held_bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (errc[0] !== 4'd4 || ffv[0] !== 3'b011 || fvalid[0] !== 1'b1 || pass[0] !== 1'b0
          || busy[0] !== 1'b0 || done[0] !== 1'b0) held_bad++;
    end
    n_vec++; if (held_bad !== 0) begin
      n_miss++; $display("FAIL results_held_idle: got %0d bad idle cycles want 0", held_bad);
    end
  endtask

  task automatic test_reset_midrun();
    int fd, ld, nd, sb, bb, stray; logic p0;
    fmode[0] = 1;
    @(negedge clk);
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    n_vec++; if (stim[0] !== 3'd4 || busy[0] !== 1'b1 || errc[0] !== 4'd1) begin
      n_miss++; $display("FAIL midrun_pre_reset: got stim=%b busy=%b err=%0d want 100 1 1",
                          stim[0], busy[0], errc[0]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++; if ({stim[0], busy[0], done[0], pass[0], fvalid[0], ffv[0], errc[0]} !== 14'd0) begin
      n_miss++; $display("FAIL midrun_async_reset: got stim=%b busy=%b fv=%b ffv=%b err=%0d want all 0",
                          stim[0], busy[0], fvalid[0], ffv[0], errc[0]);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (done[0] !== 1'b0 || busy[0] !== 1'b0) stray++;
    end
    n_vec++; if (stray !== 0) begin
      n_miss++; $display("FAIL midrun_no_done: got %0d cycles with done/busy want 0", stray);
    end
    fmode[0] = 0;
    run_obs(0, 1'b0, 1'b0, fd, ld, nd, sb, bb, p0);
    n_vec++; if (fd !== 24 || pass[0] !== 1'b1 || errc[0] !== 4'd0 || sb !== 0) begin
      n_miss++; $display("FAIL midrun_fresh_run: got done@%0d pass=%b err=%0d seqbad=%0d want 24 1 0 0",
                          fd, pass[0], errc[0], sb);
    end
  endtask

  task automatic test_settle1();
    int fd, ld, nd, sb, bb; logic p0;
    fmode[2] = 0;
    run_obs(2, 1'b0, 1'b0, fd, ld, nd, sb, bb, p0);
    n_vec++; if (fd !== 16 || nd !== 1) begin
      n_miss++; $display("FAIL settle1_done: got %0d pulses first at %0d want 1 at 16", nd, fd);
    end
    n_vec++; if (sb !== 0 || bb !== 0) begin
      n_miss++; $display("FAIL settle1_seq: got %0d stim / %0d busy bad cycles want 0", sb, bb);
    end
    n_vec++; if (pass[2] !== 1'b1 || errc[2] !== 4'd0) begin
      n_miss++; $display("FAIL settle1_result: got pass=%b err=%0d want 1 0", pass[2], errc[2]);
    end
  endtask

  task automatic test_back_to_back();
    int fd, ld, nd, sb, bb; logic p0;
    fmode[0] = 0;
    // Previous run on instance 0 passed, so pass must drop on the new start.
    run_obs(0, 1'b0, 1'b1, fd, ld, nd, sb, bb, p0);
    n_vec++; if (p0 !== 1'b0) begin n_miss++; $display("FAIL b2b_pass_cleared: got %b want 0", p0); end
    n_vec++; if (nd !== 2 || fd !== 24 || ld !== 50) begin
      n_miss++; $display("FAIL b2b_relaunch: got %0d pulses at %0d/%0d want 2 at 24/50", nd, fd, ld);
    end
    n_vec++; if (pass[0] !== 1'b1) begin n_miss++; $display("FAIL b2b_pass: got %b want 1", pass[0]); end
  endtask

  task automatic test_random();
    int fd, ld, nd, sb, bb, nm; logic p0; logic [3:0] ee; logic [2:0] ef;
    for (int r = 0; r < 6; r++) begin
      int i;
      i = r % 2;
      fmode[i] = 3;
      for (int v = 0; v < 8; v++) begin
        // Mostly correct responses with occasional corruption.
        if ($urandom_range(0, 2) == 0) ftab[i][v] = 2'($urandom_range(0, 3));
        else ftab[i][v] = 2'(((v & 1) + ((v >> 1) & 1) + ((v >> 2) & 1)));
      end
      model(i, nm, ee, ef);
      run_obs(i, 1'b0, 1'b0, fd, ld, nd, sb, bb, p0);
      n_vec++; if (errc[i] !== ee) begin
        n_miss++; $display("FAIL random%0d_err inst%0d: got %0d want %0d", r, i, errc[i], ee);
      end
      n_vec++; if (fvalid[i] !== 1'(nm > 0) || pass[i] !== 1'(nm == 0)) begin
        n_miss++; $display("FAIL random%0d_flags inst%0d: got fv=%b pass=%b want mismatches=%0d",
                            r, i, fvalid[i], pass[i], nm);
      end
      if (nm > 0) begin
        n_vec++; if (ffv[i] !== ef) begin
          n_miss++; $display("FAIL random%0d_first inst%0d: got %b want %b", r, i, ffv[i], ef);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_golden();
    test_carry_stuck();
    test_sum_inverted_sat();
    test_extra_start();
    test_reset_midrun();
    test_settle1();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
